// File: rtl/rd_burst_port.sv
// Burst read sequencer for one port of the multi-stream buffer: claims lines from the
// stream pointer manager and issues one L1 BRAM address per beat, starting past lower-port claims.
module rd_burst_port #(
    parameter int nstrms    = 64,
    parameter int sid_width = $clog2(nstrms),
    parameter int nports    = 8,
    parameter int portid    = 0,
    parameter int ptr_width = 4,
    parameter int len_width = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_rd_v,
    output logic                           i_rd_r,
    input  logic [sid_width-1:0]           i_rd_sid,
    input  logic [len_width-1:0]           i_rd_len,
    input  logic [nports-1:0]              i_cmp_v,
    input  logic [nports*sid_width-1:0]    i_cmp_sid,
    input  logic [nports*len_width-1:0]    i_cmp_len,
    input  logic [nstrms*ptr_width-1:0]    i_ptrs,
    output logic [nstrms-1:0]              o_req_v,
    input  logic [nstrms-1:0]              o_req_r,
    output logic [len_width-1:0]           o_req_len,
    output logic                           o_addr_v,
    input  logic                           o_addr_r,
    output logic [ptr_width-1:0]           o_addr_ptr,
    output logic [sid_width-1:0]           o_addr_sid,
    output logic                           o_addr_last
);

    localparam int off_width = (portid == 0) ? 1 : $clog2(portid * (2 ** len_width) + 1);

    typedef enum logic [1:0] {IDLE, CALC, BURST} state_t;

    state_t                      state;
    logic [sid_width-1:0]        s1_sid;
    logic [len_width-1:0]        s1_len;
    logic [len_width-1:0]        beat;
    logic [ptr_width-1:0]        cur_ptr;
    logic                        req_pend;
    logic [nports-1:0]           dly_cmp_v;
    logic [nports*sid_width-1:0] dly_cmp_sid;
    logic [nports*len_width-1:0] dly_cmp_len;

    logic [off_width-1:0]           offset;
    logic [ptr_width-1:0]           strm_ptr;
    logic [ptr_width+off_width-1:0] base_sum;
    logic                           addr_hs;
    logic                           claim_hs;
    logic                           beats_done;
    logic                           pend_next;

    // Lines claimed by lower-numbered ports on our stream in our acceptance cycle come first.
    always_comb begin
        offset = '0;
        for (int j = 0; j < nports; j++) begin
            if (j < portid && dly_cmp_v[j] && dly_cmp_sid[j*sid_width +: sid_width] == s1_sid) begin
                offset = offset + off_width'(dly_cmp_len[j*len_width +: len_width]) + off_width'(1);
            end
        end
    end

    always_comb begin
        strm_ptr   = i_ptrs[s1_sid*ptr_width +: ptr_width];
        base_sum   = {{off_width{1'b0}}, strm_ptr} + {{ptr_width{1'b0}}, offset};
        addr_hs    = o_addr_v & o_addr_r;
        claim_hs   = req_pend & o_req_r[s1_sid];
        beats_done = ~o_addr_v | (addr_hs & o_addr_last);
        pend_next  = req_pend & ~claim_hs;
    end

    assign i_rd_r     = (state == IDLE) & ~reset;
    assign o_req_v    = req_pend ? (nstrms'(1) << s1_sid) : '0;
    assign o_req_len  = s1_len;
    assign o_addr_ptr = cur_ptr;
    assign o_addr_sid = s1_sid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            s1_sid      <= '0;
            s1_len      <= '0;
            beat        <= '0;
            cur_ptr     <= '0;
            req_pend    <= 1'b0;
            o_addr_v    <= 1'b0;
            o_addr_last <= 1'b0;
            dly_cmp_v   <= '0;
            dly_cmp_sid <= '0;
            dly_cmp_len <= '0;
        end else begin
            dly_cmp_v   <= i_cmp_v;
            dly_cmp_sid <= i_cmp_sid;
            dly_cmp_len <= i_cmp_len;
            case (state)
                IDLE: begin
                    if (i_rd_v && i_rd_r) begin
                        s1_sid <= i_rd_sid;
                        s1_len <= i_rd_len;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    cur_ptr     <= base_sum[ptr_width-1:0];
                    beat        <= '0;
                    req_pend    <= 1'b1;
                    o_addr_v    <= 1'b1;
                    o_addr_last <= (s1_len == '0);
                    state       <= BURST;
                end
                BURST: begin
                    req_pend <= pend_next;
                    if (addr_hs) begin
                        cur_ptr <= cur_ptr + 1'b1;
                        beat    <= beat + 1'b1;
                        if (o_addr_last) begin
                            o_addr_v    <= 1'b0;
                            o_addr_last <= 1'b0;
                        end else begin
                            o_addr_last <= (beat + 1'b1 == s1_len);
                        end
                    end
                    // A finished beat stream parks with o_addr_v low until the claim lands.
                    if (beats_done && !pend_next) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
